prover_interpolate_cubic: RTL and testbench

- Prover-side helper: interpolates the unique cubic over GF(q) through four evaluations of a sum-check round polynomial.
- Evaluation points are x = 0, 1, -1 (i.e. q-1) and 2.
- Outputs the four coefficients c0..c3, so that p(x) = c0 + c1*x + c2*x^2 + c3*x^3 (mod q).
- Multi-cycle, started by a one-cycle enable; completion is signalled by a level "ready" and a one-cycle "ready_pulse".

---
 rtl/prover_interpolate_cubic.sv | 137 +++++++++++++
 tb/tb_prover_interpolate_cubic.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/prover_interpolate_cubic.sv
// Interpolates the cubic over GF(q) through p(0), p(1), p(-1), p(2) and returns
// its four coefficients after a fixed four-state sequence.
`ifndef F_NBITS
`define F_NBITS 61
`define F_Q     61'h1FFF_FFFF_FFFF_FFFF
`define F_M1    61'h1FFF_FFFF_FFFF_FFFE
`endif

module prover_interpolate_cubic (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          en,
    input  logic [3:0][`F_NBITS-1:0]      y_in,
    output logic [3:0][`F_NBITS-1:0]      c_out,
    output logic                          ready_pulse,
    output logic                          ready
);
    localparam int unsigned N  = `F_NBITS;
    localparam int unsigned NW = N + 4;
    localparam logic [N-1:0] Q = `F_Q;

    localparam logic [N:0]    Q_P1   = {1'b0, Q} + 1'b1;
    localparam logic [N-1:0]  INV2   = Q_P1[N:1];
    // q is odd and coprime to 3, so q mod 6 is 1 or 5; pick the numerator divisible by 6
    localparam logic [NW-1:0] Q_W    = {4'b0, Q};
    localparam logic [NW-1:0] INV6_W = ((Q_W % NW'(6)) == NW'(1)) ?
                                       ((NW'(5) * Q_W + NW'(1)) / NW'(6)) :
                                       ((Q_W + NW'(1)) / NW'(6));
    localparam logic [N-1:0]  INV6   = INV6_W[N-1:0];

    typedef enum logic [2:0] {IDLE, S1, S2, S3, S4} state_t;

    function automatic logic [N-1:0] add_mod(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return N'(s);
    endfunction

    function automatic logic [N-1:0] sub_mod(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        s = {1'b0, x} - {1'b0, y};
        if (x < y) s = s + {1'b0, Q};
        return N'(s);
    endfunction

    function automatic logic [N-1:0] mul_mod(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        return N'(p % {{N{1'b0}}, Q});
    endfunction

    state_t                 state_q, state_d;
    logic [3:0][N-1:0]      y_q, y_d;
    logic [N-1:0]           a_q, a_d, b_q, b_d;
    logic [N-1:0]           c2_q, c2_d, d_q, d_d, c3_q, c3_d;
    logic [3:0][N-1:0]      c_out_q, c_out_d;
    logic                   pulse_q, pulse_d;
    logic [N-1:0]           t;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        a_d     = a_q;
        b_d     = b_q;
        c2_d    = c2_q;
        d_d     = d_q;
        c3_d    = c3_q;
        c_out_d = c_out_q;
        pulse_d = 1'b0;
        t       = '0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    y_d     = y_in;
                    state_d = S1;
                end
            end
            S1: begin
                a_d     = add_mod(y_q[1], y_q[2]);
                b_d     = sub_mod(y_q[1], y_q[2]);
                state_d = S2;
            end
            S2: begin
                c2_d    = sub_mod(mul_mod(a_q, INV2), y_q[0]);
                d_d     = mul_mod(b_q, INV2);
                state_d = S3;
            end
            S3: begin
                // 6*c3 = p(2) - c0 - 4*c2 - 2*(c1+c3)
                t = sub_mod(sub_mod(sub_mod(y_q[3], y_q[0]),
                                    add_mod(add_mod(c2_q, c2_q), add_mod(c2_q, c2_q))),
                            add_mod(d_q, d_q));
                c3_d    = mul_mod(t, INV6);
                state_d = S4;
            end
            S4: begin
                c_out_d[0] = y_q[0];
                c_out_d[1] = sub_mod(d_q, c3_q);
                c_out_d[2] = c2_q;
                c_out_d[3] = c3_q;
                pulse_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q <= IDLE;
            y_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c2_q    <= '0;
            d_q     <= '0;
            c3_q    <= '0;
            c_out_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c2_q    <= c2_d;
            d_q     <= d_d;
            c3_q    <= c3_d;
            c_out_q <= c_out_d;
            pulse_q <= pulse_d;
        end
    end

    assign c_out       = c_out_q;
    assign ready_pulse = pulse_q;
    assign ready       = (state_q == IDLE);

endmodule

// File: tb/tb_prover_interpolate_cubic.sv
// Scoreboard bench for prover_interpolate_cubic: directed coefficient checks plus
// Horner re-evaluation of chained random vectors.
`ifndef F_NBITS
`define F_NBITS 61
`define F_Q     61'h1FFF_FFFF_FFFF_FFFF
`define F_M1    61'h1FFF_FFFF_FFFF_FFFE
`endif

module tb_prover_interpolate_cubic;
    localparam int unsigned N = `F_NBITS;
    localparam logic [127:0] Q128 = 128'(`F_Q);
    localparam logic [N-1:0] M1   = `F_M1;

    typedef struct {
        logic              horner;
        logic [3:0][N-1:0] v;
    } sb_item_t;

    logic              clk = 1'b0;
    logic              rstb;
    logic              en_drv;
    logic              chain;
    logic              en;
    logic [3:0][N-1:0] y_in;
    logic [3:0][N-1:0] c_out;
    logic              ready_pulse;
    logic              ready;

    sb_item_t exp_q[$];
    sb_item_t mon_item;
    int tests = 0;
    int fails = 0;
    int pulses = 0;

    assign en = en_drv | (chain & ready_pulse);

    prover_interpolate_cubic dut (
        .clk(clk), .rstb(rstb), .en(en), .y_in(y_in),
        .c_out(c_out), .ready_pulse(ready_pulse), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] horner(input logic [3:0][N-1:0] c, input logic [127:0] x);
        logic [127:0] acc;
        acc = 128'(c[3]);
        acc = (acc * x + 128'(c[2])) % Q128;
        acc = (acc * x + 128'(c[1])) % Q128;
        acc = (acc * x + 128'(c[0])) % Q128;
        return acc;
    endfunction

    function automatic logic [3:0][N-1:0] vec(input logic [N-1:0] v0, input logic [N-1:0] v1,
                                               input logic [N-1:0] v2, input logic [N-1:0] v3);
        logic [3:0][N-1:0] r;
        r[0] = v0; r[1] = v1; r[2] = v2; r[3] = v3;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rstb && ready_pulse) begin
            pulses++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got pulse with empty scoreboard, required none");
            end else begin
                mon_item = exp_q.pop_front();
                if (!mon_item.horner) begin
                    for (int i = 0; i < 4; i++)
                        check($sformatf("coef[%0d]", i), 128'(c_out[i]), 128'(mon_item.v[i]));
                end else begin
                    check("eval_p0",  horner(c_out, 128'd0),     128'(mon_item.v[0]));
                    check("eval_p1",  horner(c_out, 128'd1),     128'(mon_item.v[1]));
                    check("eval_pm1", horner(c_out, 128'(M1)),   128'(mon_item.v[2]));
                    check("eval_p2",  horner(c_out, 128'd2),     128'(mon_item.v[3]));
                end
            end
        end
    end

    task automatic push(input logic h, input logic [3:0][N-1:0] v);
        sb_item_t it;
        it.horner = h;
        it.v      = v;
        exp_q.push_back(it);
    endtask

    task automatic wait_pulse(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_pulse && n < 20);
        if (!ready_pulse) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no ready_pulse, required one within 20 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0][N-1:0] y, input logic [3:0][N-1:0] c);
        @(negedge clk);
        y_in   = y;
        en_drv = 1'b1;
        push(1'b0, c);
        @(negedge clk);
        en_drv = 1'b0;
        y_in   = '0;
        check({name, "_busy1"}, 128'(ready), 128'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("%s_busy%0d", name, k), 128'({ready, ready_pulse}), 128'd0);
        end
        @(negedge clk);
        check({name, "_done"}, 128'({ready, ready_pulse}), 128'd3);
        @(negedge clk);
        check({name, "_pulse_drop"}, 128'(ready_pulse), 128'd0);
    endtask

    initial begin
        logic [3:0][N-1:0] rv [8];
        logic [63:0] r;
        int p0;

        rstb = 1'b1; en_drv = 1'b0; chain = 1'b0; y_in = '0;
        repeat (3) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        check("rst_cout", 128'(c_out), 128'd0);
        check("rst_flags", 128'({ready, ready_pulse}), 128'd2);
        repeat (4) @(negedge clk);
        check("idle_cout", 128'(c_out), 128'd0);
        check("idle_flags", 128'({ready, ready_pulse}), 128'd2);

        run_op("const5", vec(5, 5, 5, 5), vec(5, 0, 0, 0));
        run_op("x3", vec(0, 1, M1, 8), vec(0, 0, 0, 1));
        run_op("x2", vec(0, 1, 1, 4), vec(0, 0, 1, 0));
        run_op("x1", vec(0, 1, M1, 2), vec(0, 1, 0, 0));
        run_op("allm1", vec(M1, M1 - N'(3), 0, M1 - N'(14)), vec(M1, M1, M1, M1));

        // 1 + 2x + 3x^2 + 4x^3, with a second en landing in S2
        p0 = pulses;
        @(negedge clk);
        y_in = vec(1, 10, M1 - N'(1), 49);
        en_drv = 1'b1;
        push(1'b0, vec(1, 2, 3, 4));
        @(negedge clk); en_drv = 1'b0; y_in = '0;
        @(negedge clk); en_drv = 1'b1; y_in = vec(7, 7, 7, 7);
        @(negedge clk); en_drv = 1'b0; y_in = '0;
        wait_pulse("busy_ign");
        repeat (10) @(negedge clk);
        check("busy_ign_pulses", 128'(pulses - p0), 128'd1);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                r = {$urandom, $urandom};
                rv[i][j] = N'(128'(r) % Q128);
            end
        end
        @(negedge clk);
        y_in = rv[0]; en_drv = 1'b1;
        push(1'b1, rv[0]);
        @(negedge clk);
        en_drv = 1'b0; chain = 1'b1;
        for (int i = 1; i < 8; i++) begin
            wait_pulse("chain");
            y_in = rv[i];
            push(1'b1, rv[i]);
            if (i == 7) begin
                @(negedge clk);
                chain = 1'b0;
            end
        end
        wait_pulse("chain_last");
        repeat (3) @(negedge clk);

        p0 = pulses;
        @(negedge clk);
        y_in = vec(0, 1, 1, 4); en_drv = 1'b1;
        @(negedge clk); en_drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        #1;
        check("abort_cout", 128'(c_out), 128'd0);
        check("abort_flags", 128'({ready, ready_pulse}), 128'd2);
        @(negedge clk);
        rstb = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_pulse", 128'(pulses - p0), 128'd0);
        run_op("after_abort", vec(1, 10, M1 - N'(1), 49), vec(1, 2, 3, 4));

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        check("sb_drain", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
